// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB slice first,
// and publishes S/cout/ovf only when the whole word has been processed.
module seq_adder #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   y_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   s_r;
    logic               cout_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic               accept_s;
    logic               last_s;
    logic [IW-1:0]      idx_s;
    logic [DIGIT:0]     slice_sum_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic               ovf_nxt_s;

    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s   = (cnt_r == CW'(N - 1));

    // Slice adder: one DIGIT-wide slice of the captured operands plus the running carry.
    always_comb begin
        idx_s       = {IW{1'b0}};
        slice_sum_s = {(DIGIT + 1){1'b0}};
        acc_nxt_s   = acc_r;
        ovf_nxt_s   = 1'b0;
        if (cnt_r < CW'(N)) begin
            idx_s = IW'(int'(cnt_r) * DIGIT);
        end else begin
            idx_s = {IW{1'b0}};
        end
        slice_sum_s = {1'b0, x_r[idx_s +: DIGIT]} + {1'b0, y_r[idx_s +: DIGIT]}
                    + {{DIGIT{1'b0}}, carry_r};
        acc_nxt_s[idx_s +: DIGIT] = slice_sum_s[DIGIT-1:0];
        ovf_nxt_s = (x_r[WIDTH-1] == y_r[WIDTH-1]) && (acc_nxt_s[WIDTH-1] != x_r[WIDTH-1]);
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done are registered alongside it.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RUN:  busy_nxt_s = 1'b1;
            ST_DONE: done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand capture, serial accumulation and result publish on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            x_r     <= X;
            y_r     <= sub ? ~Y : Y;
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= sub;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            acc_r   <= acc_nxt_s;
            carry_r <= slice_sum_s[DIGIT];
            cnt_r   <= cnt_r + CW'(1'b1);
            if (last_s) begin
                s_r    <= acc_nxt_s;
                cout_r <= slice_sum_s[DIGIT];
                ovf_r  <= ovf_nxt_s;
            end
        end
    end

    assign S    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, which sets the operand and sum width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 2, which sets the bits added per clock cycle; WIDTH SHALL be a multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, width 1: request to begin an operation.
REQ-006 The block SHALL have port sub, input, width 1: operation select; 0 = X+Y, 1 = X-Y. Sampled with start.
REQ-007 The block SHALL have port X, input, width WIDTH: first operand. Sampled with start.
REQ-008 The block SHALL have port Y, input, width WIDTH: second operand. Sampled with start.
REQ-009 The block SHALL have port S, output, width WIDTH: registered result.
REQ-010 The block SHALL have port cout, output, width 1: carry out of the MSB; for subtraction, 1 = no borrow.
REQ-011 The block SHALL have port ovf, output, width 1: two's-complement signed overflow.
REQ-012 The block SHALL have port busy, output, width 1: high while an operation is in progress.
REQ-013 The block SHALL have port done, output, width 1: single-cycle pulse; the result is valid in the done cycle.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL:
- capture X;
- capture Y as Y when sub=0, or ~Y when sub=1;
- capture sub;
- set the internal carry to sub;
- clear the digit counter;
- enter RUN.
REQ-016 In RUN, each rising edge SHALL add one DIGIT-bit slice (LSB slice first) of the captured operands plus the carry, store that sum slice, update the carry, and increment the counter.
REQ-017 After the N-th RUN edge, the block SHALL enter DONE and load S, cout and ovf in that same edge; done therefore rises exactly N cycles after the accepting edge.
REQ-018 DONE SHALL last one cycle; without a new start the block SHALL return to IDLE.
REQ-019 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-020 start while in RUN SHALL be ignored, with no effect on state, operands or outputs.
REQ-021 start in the DONE cycle SHALL be accepted (back-to-back operation); the next done pulse SHALL follow N cycles later.
REQ-022 S, cout and ovf SHALL change only on entry to DONE. They SHALL hold their values through IDLE and the following RUN until the next DONE, and partial sums SHALL never be visible on S.
REQ-023 cout SHALL equal the carry out of bit WIDTH-1 of X + Yeff + sub, where Yeff is the captured (possibly inverted) Y.
REQ-024 ovf SHALL be 1 when X[MSB] == Yeff[MSB] and S[MSB] != X[MSB]; otherwise ovf SHALL be 0.
REQ-025 Results SHALL wrap modulo 2^WIDTH with no saturation.
REQ-026 When DIGIT = WIDTH (N = 1), the block SHALL still take one RUN cycle; done SHALL rise 1 cycle after start.
REQ-027 The digit counter SHALL be ceil(log2(N+1)) bits wide or wider, and SHALL not wrap within an operation.

Reset
REQ-028 rst_n=0 SHALL force, asynchronously and regardless of clk, all of the following to 0: state (IDLE), S, cout, ovf, busy, done, the internal carry, the counter and the operand registers.
REQ-029 A reset asserted mid-RUN SHALL abort the operation and produce no done pulse.
REQ-030 After reset release, the first start SHALL behave as from IDLE.
REQ-031 start held high during reset SHALL be accepted only at the first rising edge after rst_n rises.

Verification
Scenarios below use WIDTH=6, DIGIT=2, N=3 unless stated.
REQ-032 Basic add: X=5, Y=3, sub=0 -> busy for 3 cycles, then done with S=001000, cout=0, ovf=0.
REQ-033 Unsigned wrap: X=63, Y=1, sub=0 -> S=000000, cout=1, ovf=0.
REQ-034 Signed overflow: X=31, Y=1, sub=0 -> S=100000, cout=0, ovf=1.
REQ-035 Subtract:
- X=5, Y=7, sub=1 -> S=111110, cout=0, ovf=0;
- X=0, Y=0, sub=1 -> S=000000, cout=1;
- X=32, Y=1, sub=1 -> S=011111, ovf=1.
REQ-036 Handshake:
- start pulsed during RUN -> ignored; exactly one done;
- start in the DONE cycle -> accepted; second done 3 cycles later;
- S stable between the two done pulses.
REQ-037 Reset mid-operation: rst_n low in the 2nd RUN cycle -> all outputs 0 at once, no done; after release, X=1, Y=1 -> S=000010.
REQ-038 Exhaustive check: all 4096 (X,Y) pairs × sub=0/1, each compared against a behavioural model on {cout,S} and ovf; the error count SHALL be 0. Repeat for DIGIT=1 (N=6) and DIGIT=6 (N=1), confirming latency N in each.
